// File: rtl/pcie_phy_pkg.sv
// Shared lane constants and types for the PHY lane datapath.
// Holds the lane byte type and lane FIFO default sizing.
package pcie_phy_pkg;

  localparam int LANE_W             = 8;
  localparam int LANE_FIFO_DEPTH    = 8;
  localparam int LANE_FIFO_AF_THRESH = 6;
  localparam int LANE_FIFO_AE_THRESH = 2;

  typedef logic [LANE_W-1:0] lane_byte_t;

  // The occupancy counter needs one extra bit so that "full" can be told apart from "empty".
  function automatic int lane_fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lane_fifo_if.sv
// Lane FIFO handshake bundle; master = producer/consumer side, slave = FIFO.
// err_* signals exist only when LANE_FIFO_ERR_EN is defined.
interface lane_fifo_if #(parameter int DATA_WIDTH = 8);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
`ifdef LANE_FIFO_ERR_EN
  logic                  err_overflow;
  logic                  err_underflow;
`endif

  modport master (
    output data_in, push, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty
`ifdef LANE_FIFO_ERR_EN
    , input err_overflow, err_underflow
`endif
  );

  modport slave (
    input  data_in, push, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty
`ifdef LANE_FIFO_ERR_EN
    , output err_overflow, err_underflow
`endif
  );

endinterface

// File: rtl/lane_fifo_mem.sv
// Register-array storage for lane_fifo: one synchronous write port and one registered read port.
// Array contents are never reset; only the read register is.
module lane_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-edge read and write of one slot returns the old entry, which is what push+pop on a full FIFO needs.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lane_fifo.sv
// Per-lane byte FIFO behind the demux; 1-cycle registered read, flags decoded from the registered count.
// Pushes are dropped when full (unless popping), pops are ignored when empty; LANE_FIFO_ERR_EN adds sticky error flags.
module lane_fifo
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_W,
  parameter int DEPTH      = LANE_FIFO_DEPTH,
  parameter int AF_THRESH  = LANE_FIFO_AF_THRESH,
  parameter int AE_THRESH  = LANE_FIFO_AE_THRESH
) (
  input  logic          clk,
  input  logic          reset,
  lane_fifo_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = lane_fifo_cnt_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  logic             valid_q;

  assign bus.full         = (count == CNT_W'(DEPTH));
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count <= CNT_W'(AE_THRESH));

  // When full, a simultaneous pop frees the slot being written, so the push is still taken.
  assign do_pop  = bus.pop && !bus.empty;
  assign do_push = bus.push && (!bus.full || bus.pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= do_pop;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.valid_out = valid_q;

  lane_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (do_push && !reset),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (do_pop),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

`ifdef LANE_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.push && !do_push) ovf_q <= 1'b1;
      if (bus.pop && bus.empty) unf_q <= 1'b1;
    end
  end

  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;
`endif

endmodule

// File: tb/tb_lane_fifo.sv
// Self-checking bench for lane_fifo: a vector table plus scoreboard-driven sequences.
// Build with LANE_FIFO_ERR_EN defined to also check the sticky error flags.
module tb_lane_fifo;
  import pcie_phy_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_fifo_if #(.DATA_WIDTH(LANE_W)) bus ();

  lane_fifo #(
    .DATA_WIDTH (LANE_W),
    .DEPTH      (DEPTH),
    .AF_THRESH  (6),
    .AE_THRESH  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  lane_byte_t mq[$];   // model contents
  lane_byte_t sb[$];   // bytes expected on data_out
  lane_byte_t exp_dout;
  bit         exp_ovf;
  bit         exp_unf;

  typedef struct {
    bit         push;
    bit         pop;
    lane_byte_t din;
    bit         v;
    lane_byte_t dout;
    bit         full;
    bit         empty;
    bit         af;
    bit         ae;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".full"},  bus.full,         32'(n == DEPTH));
    chk({tag, ".empty"}, bus.empty,        32'(n == 0));
    chk({tag, ".af"},    bus.almost_full,  32'(n >= 6));
    chk({tag, ".ae"},    bus.almost_empty, 32'(n <= 2));
`ifdef LANE_FIFO_ERR_EN
    chk({tag, ".err_ovf"}, bus.err_overflow,  32'(exp_ovf));
    chk({tag, ".err_unf"}, bus.err_underflow, 32'(exp_unf));
`endif
  endtask

  task automatic drive(input bit p, input bit q, input lane_byte_t d, input string tag);
    bit acc_pop;
    bit acc_push;
    acc_pop  = q && (mq.size() > 0);
    acc_push = p && ((mq.size() < DEPTH) || q);
    if (p && !acc_push) exp_ovf = 1'b1;
    if (q && mq.size() == 0) exp_unf = 1'b1;
    if (acc_pop)  sb.push_back(mq.pop_front());
    if (acc_push) mq.push_back(d);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    chk({tag, ".valid"}, bus.valid_out, 32'(acc_pop));
    if (acc_pop) exp_dout = sb.pop_front();
    chk({tag, ".data"}, bus.data_out, 32'(exp_dout));
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles, input bit p, input lane_byte_t d, input string tag);
    reset       = 1'b1;
    bus.push    = p;
    bus.pop     = 1'b0;
    bus.data_in = d;
    repeat (cycles) @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.push = 1'b0;
    mq.delete();
    sb.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    chk({tag, ".valid"}, bus.valid_out, 32'(0));
    chk({tag, ".data"},  bus.data_out,  32'(0));
    check_state(tag);
  endtask

  initial begin
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;

    // Reset for two cycles, then one idle cycle
    do_reset(2, 1'b0, 8'h00, "reset");
    drive(1'b0, 1'b0, 8'h00, "idle");

    tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'h44, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      logic [12:0] act;
      logic [12:0] exp;
      bus.push    = tbl[i].push;
      bus.pop     = tbl[i].pop;
      bus.data_in = tbl[i].din;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      act = {bus.valid_out, bus.data_out, bus.full, bus.empty, bus.almost_full, bus.almost_empty};
      exp = {tbl[i].v, tbl[i].dout, tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
    end

    // Fill to full, then an overflowing push
    do_reset(1, 1'b0, 8'h00, "rst_fill");
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, lane_byte_t'(i), $sformatf("fill%0d", i));
    drive(1'b1, 1'b0, 8'hFF, "overflow");

    // Drain, then one pop past empty
    for (int i = 1; i <= 9; i++) drive(1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));

    // Push and pop together on an empty FIFO: no fall-through
    drive(1'b1, 1'b1, 8'hA5, "empty_pp");
    drive(1'b0, 1'b1, 8'h00, "empty_pp_pop");

    // Full FIFO streaming with pointer wrap
    do_reset(1, 1'b0, 8'h00, "rst_wrap");
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, lane_byte_t'(8'h20 + i), $sformatf("wfill%0d", i));
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, lane_byte_t'(8'h10 + i), $sformatf("wrap%0d", i));
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'h00, $sformatf("wdrain%0d", i));

    // Mid-stream reset with a push pending
    do_reset(1, 1'b0, 8'h00, "rst_mid0");
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, lane_byte_t'(8'h50 + i), $sformatf("mid%0d", i));
    do_reset(1, 1'b1, 8'h77, "rst_mid");
    drive(1'b1, 1'b0, 8'h3C, "post_rst_push");
    drive(1'b0, 1'b1, 8'h00, "post_rst_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
